// File: rtl/axil_ibus_dbus_arbiter.sv
// Two-into-one AXI4-Lite arbiter: port 0 is the read-only instruction bus,
// port 1 the read/write data bus. One transaction is in flight at a time,
// with round-robin selection between the ports and responses routed back
// to the granted port.
module axil_ibus_dbus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,

  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_RESP,
    WR_ADDR,
    WR_RESP
  } state_e;

  state_e state_q;
  logic   gnt_q;       // port owning the current transaction
  logic   last_gnt_q;  // port granted most recently
  logic   aw_done_q;
  logic   w_done_q;

  logic req0, req1, win;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Response payloads are unregistered; they only matter under their valid.
  assign s0_axil_rdata = m_axil_rdata;
  assign s0_axil_rresp = m_axil_rresp;
  assign s1_axil_rdata = m_axil_rdata;
  assign s1_axil_rresp = m_axil_rresp;
  assign s1_axil_bresp = m_axil_bresp;

  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign r_hs  = m_axil_rvalid  & m_axil_rready;
  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid  & m_axil_wready;
  assign b_hs  = m_axil_bvalid  & m_axil_bready;

  // Round-robin pick: on a tie the port that was not granted last wins.
  always_comb begin
    req0 = s0_axil_arvalid;
    req1 = s1_axil_awvalid | s1_axil_arvalid;
    win  = (req0 & req1) ? ~last_gnt_q : req1;
  end

  // Transaction sequencing, grant registration and write-channel tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            gnt_q      <= win;
            last_gnt_q <= win;
            state_q    <= (win & s1_axil_awvalid) ? WR_ADDR : RD_ADDR;
          end
        end
        RD_ADDR: if (ar_hs) state_q <= RD_RESP;
        RD_RESP: if (r_hs)  state_q <= IDLE;
        WR_ADDR: begin
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        WR_RESP: if (b_hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational routing of the granted port; reset forces every
  // handshake signal low even while the state register still holds a
  // mid-transaction value.
  always_comb begin
    s0_axil_arready = 1'b0;
    s0_axil_rvalid  = 1'b0;
    s1_axil_awready = 1'b0;
    s1_axil_wready  = 1'b0;
    s1_axil_bvalid  = 1'b0;
    s1_axil_arready = 1'b0;
    s1_axil_rvalid  = 1'b0;
    m_axil_awaddr   = '0;
    m_axil_awprot   = '0;
    m_axil_awvalid  = 1'b0;
    m_axil_wdata    = '0;
    m_axil_wstrb    = '0;
    m_axil_wvalid   = 1'b0;
    m_axil_bready   = 1'b0;
    m_axil_araddr   = '0;
    m_axil_arprot   = '0;
    m_axil_arvalid  = 1'b0;
    m_axil_rready   = 1'b0;
    if (!rst) begin
      case (state_q)
        RD_ADDR, RD_RESP: begin
          m_axil_araddr = gnt_q ? s1_axil_araddr : s0_axil_araddr;
          m_axil_arprot = gnt_q ? s1_axil_arprot : s0_axil_arprot;
          if (state_q == RD_ADDR) begin
            m_axil_arvalid = gnt_q ? s1_axil_arvalid : s0_axil_arvalid;
            if (gnt_q) s1_axil_arready = m_axil_arready;
            else       s0_axil_arready = m_axil_arready;
          end else begin
            m_axil_rready = gnt_q ? s1_axil_rready : s0_axil_rready;
            if (gnt_q) s1_axil_rvalid = m_axil_rvalid;
            else       s0_axil_rvalid = m_axil_rvalid;
          end
        end
        WR_ADDR, WR_RESP: begin
          m_axil_awaddr = s1_axil_awaddr;
          m_axil_awprot = s1_axil_awprot;
          m_axil_wdata  = s1_axil_wdata;
          m_axil_wstrb  = s1_axil_wstrb;
          if (state_q == WR_ADDR) begin
            m_axil_awvalid  = s1_axil_awvalid & ~aw_done_q;
            s1_axil_awready = m_axil_awready  & ~aw_done_q;
            m_axil_wvalid   = s1_axil_wvalid  & ~w_done_q;
            s1_axil_wready  = m_axil_wready   & ~w_done_q;
          end else begin
            s1_axil_bvalid = m_axil_bvalid;
            m_axil_bready  = s1_axil_bready;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ibus_dbus_arbiter.sv
// Self-checking bench for axil_ibus_dbus_arbiter: directed scenarios plus a
// randomized run, all checked cycle by cycle against a transaction-level
// reference model of the arbiter.
module tb_axil_ibus_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_axil_araddr;
  logic [2:0]  s0_axil_arprot;
  logic        s0_axil_arvalid, s0_axil_arready;
  logic [31:0] s0_axil_rdata;
  logic [1:0]  s0_axil_rresp;
  logic        s0_axil_rvalid, s0_axil_rready;
  logic [31:0] s1_axil_awaddr;
  logic [2:0]  s1_axil_awprot;
  logic        s1_axil_awvalid, s1_axil_awready;
  logic [31:0] s1_axil_wdata;
  logic [3:0]  s1_axil_wstrb;
  logic        s1_axil_wvalid, s1_axil_wready;
  logic [1:0]  s1_axil_bresp;
  logic        s1_axil_bvalid, s1_axil_bready;
  logic [31:0] s1_axil_araddr;
  logic [2:0]  s1_axil_arprot;
  logic        s1_axil_arvalid, s1_axil_arready;
  logic [31:0] s1_axil_rdata;
  logic [1:0]  s1_axil_rresp;
  logic        s1_axil_rvalid, s1_axil_rready;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid, m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid, m_axil_rready;

  axil_ibus_dbus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_axil_araddr(s0_axil_araddr), .s0_axil_arprot(s0_axil_arprot),
    .s0_axil_arvalid(s0_axil_arvalid), .s0_axil_arready(s0_axil_arready),
    .s0_axil_rdata(s0_axil_rdata), .s0_axil_rresp(s0_axil_rresp),
    .s0_axil_rvalid(s0_axil_rvalid), .s0_axil_rready(s0_axil_rready),
    .s1_axil_awaddr(s1_axil_awaddr), .s1_axil_awprot(s1_axil_awprot),
    .s1_axil_awvalid(s1_axil_awvalid), .s1_axil_awready(s1_axil_awready),
    .s1_axil_wdata(s1_axil_wdata), .s1_axil_wstrb(s1_axil_wstrb),
    .s1_axil_wvalid(s1_axil_wvalid), .s1_axil_wready(s1_axil_wready),
    .s1_axil_bresp(s1_axil_bresp), .s1_axil_bvalid(s1_axil_bvalid),
    .s1_axil_bready(s1_axil_bready),
    .s1_axil_araddr(s1_axil_araddr), .s1_axil_arprot(s1_axil_arprot),
    .s1_axil_arvalid(s1_axil_arvalid), .s1_axil_arready(s1_axil_arready),
    .s1_axil_rdata(s1_axil_rdata), .s1_axil_rresp(s1_axil_rresp),
    .s1_axil_rvalid(s1_axil_rvalid), .s1_axil_rready(s1_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Handshake-vector bit positions:
  // {s0_arready, s0_rvalid, s1_awready, s1_wready, s1_bvalid, s1_arready,
  //  s1_rvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}
  localparam int S0_ARREADY = 11, S0_RVALID = 10, S1_AWREADY = 9, S1_WREADY = 8;
  localparam int S1_BVALID = 7, S1_ARREADY = 6, S1_RVALID = 5, M_AWVALID = 4;
  localparam int M_WVALID = 3, M_BREADY = 2, M_ARVALID = 1, M_RREADY = 0;

  // Reference model: the transaction currently owned by a port, if any.
  bit mb_busy, mb_port, mb_wr, mb_addr_ok, mb_aw_ok, mb_w_ok, mb_last;

  logic [11:0] obs_v;
  logic [33:0] obs_r0, obs_r1;
  logic [1:0]  obs_b;
  int          gq[$];   // observed grant order: 0 = s0 read, 1 = s1 read, 2 = s1 write
  bit hs_s0ar, hs_s1ar, hs_s1aw, hs_s1w, hs_mr, hs_mb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_out();
    logic s0ar, s0r, s1aw, s1w, s1b, s1ar, s1r, maw, mw, mbr, mar, mr;
    {s0ar, s0r, s1aw, s1w, s1b, s1ar, s1r, maw, mw, mbr, mar, mr} = '0;
    if (!rst && mb_busy) begin
      if (!mb_wr) begin
        if (!mb_addr_ok) begin
          mar = mb_port ? s1_axil_arvalid : s0_axil_arvalid;
          if (mb_port) s1ar = m_axil_arready; else s0ar = m_axil_arready;
        end else begin
          mr = mb_port ? s1_axil_rready : s0_axil_rready;
          if (mb_port) s1r = m_axil_rvalid; else s0r = m_axil_rvalid;
        end
      end else if (!(mb_aw_ok && mb_w_ok)) begin
        maw  = s1_axil_awvalid & !mb_aw_ok;
        s1aw = m_axil_awready  & !mb_aw_ok;
        mw   = s1_axil_wvalid  & !mb_w_ok;
        s1w  = m_axil_wready   & !mb_w_ok;
      end else begin
        s1b = m_axil_bvalid;
        mbr = s1_axil_bready;
      end
    end
    return {s0ar, s0r, s1aw, s1w, s1b, s1ar, s1r, maw, mw, mbr, mar, mr};
  endfunction

  task automatic model_update(input logic [11:0] e);
    bit r0, r1, w;
    if (rst) begin
      mb_busy = 0; mb_last = 1; mb_addr_ok = 0; mb_aw_ok = 0; mb_w_ok = 0;
    end else if (!mb_busy) begin
      r0 = s0_axil_arvalid;
      r1 = s1_axil_awvalid | s1_axil_arvalid;
      if (r0 || r1) begin
        w = (r0 && r1) ? !mb_last : r1;
        mb_busy = 1; mb_port = w; mb_wr = w && s1_axil_awvalid;
        mb_addr_ok = 0; mb_aw_ok = 0; mb_w_ok = 0; mb_last = w;
      end
    end else if (!mb_wr) begin
      if (!mb_addr_ok) begin
        if (e[M_ARVALID] && m_axil_arready) mb_addr_ok = 1;
      end else if (e[M_RREADY] && m_axil_rvalid) mb_busy = 0;
    end else if (!(mb_aw_ok && mb_w_ok)) begin
      if (e[M_AWVALID] && m_axil_awready) mb_aw_ok = 1;
      if (e[M_WVALID] && m_axil_wready) mb_w_ok = 1;
    end else if (e[M_BREADY] && m_axil_bvalid) mb_busy = 0;
  endtask

  // One clock: sample and check mid-cycle, advance the model, return just
  // after the rising edge so the caller can drive the next cycle's inputs.
  task automatic step();
    logic [11:0] e;
    @(negedge clk);
    e = model_out();
    obs_v = {s0_axil_arready, s0_axil_rvalid, s1_axil_awready, s1_axil_wready,
             s1_axil_bvalid, s1_axil_arready, s1_axil_rvalid, m_axil_awvalid,
             m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready};
    obs_r0 = {s0_axil_rresp, s0_axil_rdata};
    obs_r1 = {s1_axil_rresp, s1_axil_rdata};
    obs_b  = s1_axil_bresp;
    check("hs_vec", 64'(obs_v), 64'(e));
    if (rst || !mb_busy) begin
      check("idle_ar", 64'({m_axil_arprot, m_axil_araddr}), 64'd0);
      check("idle_aw", 64'({m_axil_awprot, m_axil_awaddr}), 64'd0);
      check("idle_w",  64'({m_axil_wstrb, m_axil_wdata}), 64'd0);
    end
    if (e[M_ARVALID])
      check("ar_payload", 64'({m_axil_arprot, m_axil_araddr}),
            mb_port ? 64'({s1_axil_arprot, s1_axil_araddr}) : 64'({s0_axil_arprot, s0_axil_araddr}));
    if (e[M_AWVALID]) check("aw_payload", 64'({m_axil_awprot, m_axil_awaddr}), 64'({s1_axil_awprot, s1_axil_awaddr}));
    if (e[M_WVALID])  check("w_payload", 64'({m_axil_wstrb, m_axil_wdata}), 64'({s1_axil_wstrb, s1_axil_wdata}));
    if (e[S0_RVALID]) check("s0_r_payload", 64'(obs_r0), 64'({m_axil_rresp, m_axil_rdata}));
    if (e[S1_RVALID]) check("s1_r_payload", 64'(obs_r1), 64'({m_axil_rresp, m_axil_rdata}));
    if (e[S1_BVALID]) check("s1_bresp", 64'(obs_b), 64'(m_axil_bresp));
    hs_s0ar = s0_axil_arvalid & s0_axil_arready;
    hs_s1ar = s1_axil_arvalid & s1_axil_arready;
    hs_s1aw = s1_axil_awvalid & s1_axil_awready;
    hs_s1w  = s1_axil_wvalid  & s1_axil_wready;
    hs_mr   = m_axil_rvalid   & m_axil_rready;
    hs_mb   = m_axil_bvalid   & m_axil_bready;
    if (hs_s0ar) gq.push_back(0);
    if (hs_s1ar) gq.push_back(1);
    if (hs_s1aw) gq.push_back(2);
    model_update(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_axil_araddr = '0; s0_axil_arprot = '0; s0_axil_arvalid = 0; s0_axil_rready = 0;
    s1_axil_awaddr = '0; s1_axil_awprot = '0; s1_axil_awvalid = 0;
    s1_axil_wdata = '0; s1_axil_wstrb = '0; s1_axil_wvalid = 0; s1_axil_bready = 0;
    s1_axil_araddr = '0; s1_axil_arprot = '0; s1_axil_arvalid = 0; s1_axil_rready = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_bresp = '0; m_axil_bvalid = 0;
    m_axil_arready = 0; m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    check("reset_outputs", 64'(obs_v), 64'd0);
    rst = 0;
  endtask

  function automatic int gnt_at(input int i);
    return (i < gq.size()) ? gq[i] : 99;
  endfunction

  // Protocol-abiding random masters and slave: a valid is held until its
  // handshake, then a fresh transfer may start with new payload.
  task automatic rand_drive();
    rst = ($urandom_range(0, 299) == 0);
    if (!s0_axil_arvalid || hs_s0ar) begin
      s0_axil_arvalid = ($urandom_range(0, 2) == 0);
      s0_axil_araddr  = $urandom; s0_axil_arprot = 3'($urandom_range(0, 7));
    end
    if (!s1_axil_arvalid || hs_s1ar) begin
      s1_axil_arvalid = ($urandom_range(0, 2) == 0);
      s1_axil_araddr  = $urandom; s1_axil_arprot = 3'($urandom_range(0, 7));
    end
    if (!s1_axil_awvalid || hs_s1aw) begin
      s1_axil_awvalid = ($urandom_range(0, 3) == 0);
      s1_axil_awaddr  = $urandom; s1_axil_awprot = 3'($urandom_range(0, 7));
    end
    if (!s1_axil_wvalid || hs_s1w) begin
      s1_axil_wvalid = ($urandom_range(0, 2) == 0);
      s1_axil_wdata  = $urandom; s1_axil_wstrb = 4'($urandom_range(0, 15));
    end
    if (!m_axil_rvalid || hs_mr) begin
      m_axil_rvalid = ($urandom_range(0, 2) == 0);
      m_axil_rdata  = $urandom; m_axil_rresp = 2'($urandom_range(0, 3));
    end
    if (!m_axil_bvalid || hs_mb) begin
      m_axil_bvalid = ($urandom_range(0, 2) == 0);
      m_axil_bresp  = 2'($urandom_range(0, 3));
    end
    s0_axil_rready = ($urandom_range(0, 2) != 0);
    s1_axil_rready = ($urandom_range(0, 2) != 0);
    s1_axil_bready = ($urandom_range(0, 2) != 0);
    m_axil_arready = ($urandom_range(0, 2) != 0);
    m_axil_awready = ($urandom_range(0, 2) != 0);
    m_axil_wready  = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    bit aw_set;
    rst = 1;
    clear_inputs();
    mb_busy = 0; mb_last = 1;

    // Single zero-wait read on port 0.
    do_reset();
    s0_axil_arvalid = 1; s0_axil_araddr = 32'h0000_0100; m_axil_arready = 1;
    step();
    check("t1_c0_no_arvalid", 64'(obs_v[M_ARVALID]), 64'd0);
    step();
    check("t1_c1_arvalid", 64'(obs_v[M_ARVALID]), 64'd1);
    s0_axil_arvalid = 0; m_axil_rvalid = 1; m_axil_rdata = 32'hDEAD_BEEF;
    m_axil_rresp = 2'd0; s0_axil_rready = 1;
    step();
    check("t1_c2_s0_rvalid", 64'(obs_v[S0_RVALID]), 64'd1);
    check("t1_c2_s0_rdata", 64'(obs_r0), 64'h0_DEAD_BEEF);
    check("t1_c2_s1_quiet", 64'(obs_v[S1_AWREADY:S1_RVALID]), 64'd0);
    m_axil_rvalid = 0; s0_axil_rready = 0;
    step();
    check("t1_c3_idle", 64'(obs_v), 64'd0);

    // Tie between ports, with a port-1 write joining mid-run.
    do_reset();
    gq.delete(); aw_set = 0;
    s0_axil_arvalid = 1; s1_axil_arvalid = 1; m_axil_arready = 1; m_axil_rvalid = 1;
    s0_axil_rready = 1; s1_axil_rready = 1; m_axil_awready = 1; m_axil_wready = 1;
    m_axil_bvalid = 1; s1_axil_bready = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (hs_s1aw) begin s1_axil_awvalid = 0; s1_axil_wvalid = 0; end
      if (gq.size() == 3 && !aw_set) begin
        s1_axil_awvalid = 1; s1_axil_wvalid = 1; s1_axil_awaddr = 32'h0000_4000;
        s1_axil_wdata = 32'hCAFE_0001; s1_axil_wstrb = 4'h3; aw_set = 1;
      end
    end
    check("t2_grant0", 64'(gnt_at(0)), 64'd0);
    check("t2_grant1", 64'(gnt_at(1)), 64'd1);
    check("t2_grant2", 64'(gnt_at(2)), 64'd0);
    check("t2_grant3_write_first", 64'(gnt_at(3)), 64'd2);
    check("t2_grant4", 64'(gnt_at(4)), 64'd0);

    // Write with W accepted well before AW.
    do_reset();
    s1_axil_awvalid = 1; s1_axil_awaddr = 32'h0000_2000; s1_axil_wvalid = 1;
    s1_axil_wdata = 32'h1234_5678; s1_axil_wstrb = 4'hF;
    step();
    m_axil_wready = 1;
    step();
    check("t3_c1_w_accept", 64'(obs_v[S1_WREADY]), 64'd1);
    step();
    check("t3_c2_wvalid_masked", 64'(obs_v[M_WVALID]), 64'd0);
    check("t3_c2_awvalid", 64'(obs_v[M_AWVALID]), 64'd1);
    m_axil_bvalid = 1; m_axil_bresp = 2'd2; s1_axil_bready = 1;
    step();
    check("t3_c3_wvalid_masked", 64'(obs_v[M_WVALID]), 64'd0);
    check("t3_c3_early_b_ignored", 64'(obs_v[M_BREADY]), 64'd0);
    m_axil_awready = 1;
    step();
    check("t3_c4_aw_accept", 64'(obs_v[S1_AWREADY]), 64'd1);
    s1_axil_awvalid = 0; s1_axil_wvalid = 0;
    step();
    check("t3_c5_bvalid", 64'(obs_v[S1_BVALID]), 64'd1);
    check("t3_c5_bready", 64'(obs_v[M_BREADY]), 64'd1);
    check("t3_c5_bresp", 64'(obs_b), 64'd2);
    m_axil_bvalid = 0;
    step();
    check("t3_c6_idle", 64'(obs_v), 64'd0);

    // Read-response backpressure from port 0.
    do_reset();
    s0_axil_arvalid = 1; s0_axil_araddr = 32'h0000_0200; m_axil_arready = 1;
    step(); step();
    s0_axil_arvalid = 0; m_axil_rvalid = 1; m_axil_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_rready", 64'(obs_v[M_RREADY]), 64'd0);
      check("t4_hold_rvalid", 64'(obs_v[S0_RVALID]), 64'd1);
    end
    s0_axil_rready = 1;
    step();
    check("t4_release_rready", 64'(obs_v[M_RREADY]), 64'd1);
    step();
    check("t4_done_no_rvalid", 64'(obs_v[S0_RVALID]), 64'd0);
    check("t4_done_no_rready", 64'(obs_v[M_RREADY]), 64'd0);
    m_axil_rvalid = 0; s0_axil_rready = 0;

    // Reset while port 0 waits for its read response.
    do_reset();
    s0_axil_arvalid = 1; s0_axil_araddr = 32'h0000_0300; m_axil_arready = 1;
    step(); step();
    s0_axil_arvalid = 0;
    step();
    rst = 1;
    step();
    check("t5_in_reset", 64'(obs_v), 64'd0);
    rst = 0; m_axil_rvalid = 1; s0_axil_rready = 1;
    step();
    check("t5_late_resp_dropped", 64'(obs_v), 64'd0);
    m_axil_rvalid = 0; s0_axil_rready = 0;
    gq.delete();
    s0_axil_arvalid = 1; s1_axil_arvalid = 1; s1_axil_araddr = 32'h0000_3000;
    step(); step();
    s0_axil_arvalid = 0; m_axil_rvalid = 1; m_axil_rdata = 32'h1111_2222; s0_axil_rready = 1;
    step();
    m_axil_rvalid = 0;
    step(); step();
    s1_axil_arvalid = 0; m_axil_rvalid = 1; m_axil_rdata = 32'h55AA_33CC; s1_axil_rready = 1;
    step();
    check("t5_s1_rvalid", 64'(obs_v[S1_RVALID]), 64'd1);
    check("t5_s1_rdata", 64'(obs_r1), 64'h0_55AA_33CC);
    check("t5_tie_port0_first", 64'(gnt_at(0)), 64'd0);
    check("t5_then_port1", 64'(gnt_at(1)), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rand_drive();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
